// File: rtl/led_pattern_gen.sv
// led_pattern_gen
//   Generates the LED word for the downstream LED driver. Software picks a
//   pattern mode and seed with a one-cycle load strobe; the pattern then steps
//   once every TICK_DIV enabled clocks.
//
//   Modes: 0 STATIC (hold seed), 1 COUNT (binary up-count from seed),
//          2 SHIFT (rotate-left one-hot), 3 BOUNCE (one-hot ping-pong).
//
//   Ports:
//     clk        in   system clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     mode       in   pattern select, sampled on load
//     sw_value   in   seed / static value, sampled on load
//     load       in   one-cycle strobe applying mode and sw_value
//     enable     in   1 = pattern advances, 0 = freeze
//     duty       in   (LED_PATTERN_PWM_EN only) 4-bit brightness, 15 = full on
//     led_out    out  registered LED word
//     step_tick  out  one-cycle pulse following each pattern step
//
//   Optional build macro: LED_PATTERN_PWM_EN adds the duty input and a 16-slot
//   PWM gate on led_out. Without it led_out is the pattern register itself.
module led_pattern_gen #(
    parameter int TICK_DIV = 50000000,
    parameter int LED_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [LED_W-1:0] sw_value,
    input  logic             load,
    input  logic             enable,
`ifdef LED_PATTERN_PWM_EN
    input  logic [3:0]       duty,
`endif
    output logic [LED_W-1:0] led_out,
    output logic             step_tick
);

    localparam int               PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PS_MAX = PW'(TICK_DIV - 1);
    localparam logic [LED_W-1:0] ONE    = LED_W'(1);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_COUNT  = 2'd1,
        MODE_SHIFT  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    mode_t            mode_r, mode_n;
    dir_t             dir_r,  dir_n;
    logic [PW-1:0]    pres_r, pres_n;
    logic [LED_W-1:0] pat_r,  pat_n;
    logic             tick_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r    <= MODE_STATIC;
            dir_r     <= DIR_LEFT;
            pres_r    <= '0;
            pat_r     <= '0;
            step_tick <= 1'b0;
        end else begin
            mode_r    <= mode_n;
            dir_r     <= dir_n;
            pres_r    <= pres_n;
            pat_r     <= pat_n;
            step_tick <= tick_n;
        end
    end

    // Load takes priority over a coincident step: the step is dropped and the
    // prescaler restarts from zero.
    always_comb begin
        mode_n = mode_r;
        dir_n  = dir_r;
        pres_n = pres_r;
        pat_n  = pat_r;
        tick_n = 1'b0;
        if (load) begin
            mode_n = mode_t'(mode);
            pres_n = '0;
            case (mode_t'(mode))
                MODE_STATIC: pat_n = sw_value;
                MODE_COUNT:  pat_n = sw_value;
                MODE_SHIFT:  pat_n = ONE;
                MODE_BOUNCE: begin
                    pat_n = ONE;
                    dir_n = DIR_LEFT;
                end
                default:     pat_n = sw_value;
            endcase
        end else if (enable) begin
            if (pres_r == PS_MAX) begin
                pres_n = '0;
                tick_n = 1'b1;
                case (mode_r)
                    MODE_STATIC: pat_n = pat_r;
                    MODE_COUNT:  pat_n = pat_r + ONE;
                    MODE_SHIFT:  pat_n = {pat_r[LED_W-2:0], pat_r[LED_W-1]};
                    MODE_BOUNCE: begin
                        // Reverse at either end so the end bit is shown once.
                        if (dir_r == DIR_LEFT) begin
                            if (pat_r[LED_W-1]) begin
                                dir_n = DIR_RIGHT;
                                pat_n = pat_r >> 1;
                            end else begin
                                pat_n = pat_r << 1;
                            end
                        end else begin
                            if (pat_r[0]) begin
                                dir_n = DIR_LEFT;
                                pat_n = pat_r << 1;
                            end else begin
                                pat_n = pat_r >> 1;
                            end
                        end
                    end
                    default:     pat_n = pat_r;
                endcase
            end else begin
                pres_n = pres_r + PW'(1);
            end
        end
    end

`ifdef LED_PATTERN_PWM_EN
    logic [3:0]       pwm_cnt;
    logic             gate;
    logic [LED_W-1:0] led_q;

    assign gate = (pwm_cnt < duty) || (duty == 4'hF);

    // Gate the next pattern value so load/step latency stays one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            led_q   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            led_q   <= pat_n & {LED_W{gate}};
        end
    end

    assign led_out = led_q;
`else
    assign led_out = pat_r;
`endif

endmodule
